// File: rtl/pinger_pkg.sv
// pinger_pkg: shared FSM states, 50 MHz cycle defaults and the published result record.
package pinger_pkg;
  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, GAP} state_t;
  localparam int DEF_CHANNELS       = 4;
  localparam int DEF_TRIG_CYCLES    = 500;
  localparam int DEF_TIMEOUT_CYCLES = 1_900_000;
  localparam int DEF_GAP_CYCLES     = 3_000_000;
  localparam int DEF_NEAR_CYCLES    = 29_000;
  localparam int DEF_CNT_W          = 22;
  localparam int DEF_CH_W           = 2;
  typedef struct packed {
    logic [DEF_CH_W-1:0]  ch;
    logic [DEF_CNT_W-1:0] width;
    logic                 timeout;
  } result_t;
endpackage

// File: rtl/echo_sync.sv
// echo_sync: 2-flop synchroniser plus edge-detect register for one echo input.
module echo_sync (
  input  logic clk,
  input  logic rst,
  input  logic echo_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic s1_q, s2_q, prev_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= echo_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end
  assign level_o = s2_q;
  assign rise_o  = s2_q & ~prev_q;
  assign fall_o  = ~s2_q & prev_q;
endmodule

// File: rtl/multi_pinger.sv
// multi_pinger: round-robin multi-channel ultrasonic ranging controller.
module multi_pinger
  import pinger_pkg::*;
#(
  parameter int CHANNELS       = DEF_CHANNELS,
  parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int NEAR_CYCLES    = DEF_NEAR_CYCLES,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int CH_W           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  output logic [CHANNELS-1:0] trig,
  input  logic [CHANNELS-1:0] echo,
  output logic                result_valid,
  output logic [CH_W-1:0]     result_ch,
  output logic [CNT_W-1:0]    result_width,
  output logic                result_timeout,
  output logic [CHANNELS-1:0] near
);
  localparam logic [CNT_W-1:0] TRIG_END = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO       = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TO_END   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] NEAR_TH  = CNT_W'(NEAR_CYCLES);
  logic [CHANNELS-1:0] rise_w, fall_w, level_w, trig_q, near_q;
  state_t              state_q;
  logic [CH_W-1:0]     ch_q, ch_nxt;
  logic [CNT_W-1:0]    cnt_q, cnt_inc, pub_w;
  result_t             res_q;
  logic                valid_q, rise, fall, level, pub, pub_to;
  for (genvar g = 0; g < CHANNELS; g++) begin : g_sync
    echo_sync u_sync (
      .clk    (clk),
      .rst    (rst),
      .echo_i (echo[g]),
      .level_o(level_w[g]),
      .rise_o (rise_w[g]),
      .fall_o (fall_w[g])
    );
  end
  // only the active channel's synchronised echo is ever observed
  always_comb begin
    rise    = rise_w[ch_q];
    fall    = fall_w[ch_q];
    level   = level_w[ch_q];
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    ch_nxt  = (ch_q == CH_W'(CHANNELS - 1)) ? '0 : ch_q + 1'b1;
    pub     = (state_q == WAIT_RISE && !rise && cnt_q == TO_END) ||
              (state_q == MEASURE && (fall || cnt_q >= TO));
    pub_to  = !(state_q == MEASURE && fall);
    pub_w   = (state_q == MEASURE) ? (fall ? cnt_q : TO) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ch_q    <= '0;
      cnt_q   <= '0;
      trig_q  <= '0;
      valid_q <= 1'b0;
      res_q   <= '0;
      near_q  <= '0;
    end else begin
      valid_q <= pub;
      if (pub) begin
        res_q        <= '{ch: DEF_CH_W'(ch_q), width: DEF_CNT_W'(pub_w), timeout: pub_to};
        near_q[ch_q] <= !pub_to && pub_w < NEAR_TH;
        state_q      <= GAP;
        cnt_q        <= '0;
      end else begin
        case (state_q)
          IDLE: if (enable) begin
            state_q <= TRIG;
            trig_q  <= CHANNELS'(1) << ch_q;
            cnt_q   <= '0;
          end
          TRIG: if (cnt_q == TRIG_END) begin
            state_q <= WAIT_RISE;
            trig_q  <= '0;
            cnt_q   <= '0;
          end else cnt_q <= cnt_inc;
          WAIT_RISE: if (rise) begin
            state_q <= MEASURE;
            cnt_q   <= CNT_W'(1);
          end else cnt_q <= cnt_inc;
          MEASURE: if (level) cnt_q <= cnt_inc;
          GAP: if (cnt_q == GAP_END) begin
            ch_q    <= ch_nxt;
            state_q <= enable ? TRIG : IDLE;
            trig_q  <= enable ? CHANNELS'(1) << ch_nxt : '0;
            cnt_q   <= '0;
          end else cnt_q <= cnt_inc;
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign trig           = trig_q;
  assign result_valid   = valid_q;
  assign result_ch      = CH_W'(res_q.ch);
  assign result_width   = CNT_W'(res_q.width);
  assign result_timeout = res_q.timeout;
  assign near           = near_q;
endmodule
